// File: rtl/projectile_ctl_dog_if.sv
`default_nettype none
// ============================================================================
// Module   : projectile_ctl_dog_if
// Brief    : Game-FSM / drawer bundle for the dog projectile controller.
// Revision : 1.0
// ============================================================================
interface projectile_ctl_dog_if;
    logic        frame_tick;
    logic        throw;
    logic [7:0]  vx_init;
    logic [7:0]  vy_init;
    logic [5:0]  wind;
    logic        active;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        busy;
    logic        hit;
    logic        miss;

    modport master (
        output frame_tick, throw, vx_init, vy_init, wind,
        input  active, x_pos, y_pos, busy, hit, miss
    );

    modport slave (
        input  frame_tick, throw, vx_init, vy_init, wind,
        output active, x_pos, y_pos, busy, hit, miss
    );
endinterface
`default_nettype wire

// File: rtl/projectile_ctl_dog.sv
`default_nettype none
// ============================================================================
// Module   : projectile_ctl_dog
// Brief    : Frame-stepped ballistic flight of the dog projectile, hit/miss.
// Revision : 1.0
// ============================================================================
module projectile_ctl_dog #(
    parameter int START_X   = 40,
    parameter int START_Y   = 120,
    parameter int GRAVITY   = 2,
    parameter int TGT_X_MIN = 700,
    parameter int TGT_X_MAX = 760,
    parameter int TGT_Y_MAX = 100
) (
    input wire clk,
    input wire rst,
    projectile_ctl_dog_if.slave ctl
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_FLIGHT = 2'd2;
    localparam logic [1:0] S_LANDED = 2'd3;

    localparam logic signed [13:0] HOR_PIXELS = 14'sd800;
    localparam logic signed [13:0] TX_MIN     = 14'(TGT_X_MIN);
    localparam logic signed [13:0] TX_MAX     = 14'(TGT_X_MAX);
    localparam logic signed [13:0] TY_MAX     = 14'(TGT_Y_MAX);

    logic [1:0]         state_q, state_d;
    logic signed [17:0] x_fp_q, x_fp_d, y_fp_q, y_fp_d;
    logic signed [11:0] vx_q, vx_d, vy_q, vy_d;
    logic [7:0]         vxi_q, vxi_d, vyi_q, vyi_d;
    logic [11:0]        x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic               active_q, active_d, hit_q, hit_d, miss_q, miss_d;

    logic signed [17:0] w_x_new, w_y_new;
    logic signed [13:0] w_x_int, w_y_int;
    logic signed [12:0] w_vx_sum, w_vy_dif;
    logic signed [11:0] w_vx_sat, w_vy_sat;
    logic [11:0]        w_x_clamp, w_y_clamp;
    logic               w_hit, w_ground, w_edge;

    assign w_x_new  = x_fp_q + {{6{vx_q[11]}}, vx_q};
    assign w_y_new  = y_fp_q + {{6{vy_q[11]}}, vy_q};
    assign w_x_int  = w_x_new[17:4];
    assign w_y_int  = w_y_new[17:4];

    // Velocity updates widen by one bit, then saturate on sign disagreement.
    assign w_vx_sum = {vx_q[11], vx_q} + {{7{ctl.wind[5]}}, ctl.wind};
    assign w_vy_dif = {vy_q[11], vy_q} - 13'(GRAVITY);
    assign w_vx_sat = (w_vx_sum[12] == w_vx_sum[11]) ? w_vx_sum[11:0]
                    : (w_vx_sum[12] ? 12'sh800 : 12'sh7FF);
    assign w_vy_sat = (w_vy_dif[12] == w_vy_dif[11]) ? w_vy_dif[11:0]
                    : (w_vy_dif[12] ? 12'sh800 : 12'sh7FF);

    // Negative y counts as height 0, which is always inside the hitbox.
    assign w_hit    = (w_x_int >= TX_MIN) && (w_x_int <= TX_MAX) &&
                      (w_y_new[17] || (w_y_int <= TY_MAX));
    assign w_ground = w_y_new[17];
    assign w_edge   = w_x_new[17] || (w_x_int >= HOR_PIXELS);

    assign w_x_clamp = w_x_new[17] ? 12'd0
                     : (w_x_int >= HOR_PIXELS) ? 12'(HOR_PIXELS - 14'sd1)
                     : w_x_new[15:4];
    assign w_y_clamp = w_y_new[17] ? 12'd0
                     : w_y_new[16] ? 12'hFFF
                     : w_y_new[15:4];

    always_comb begin
        state_d  = state_q;
        x_fp_d   = x_fp_q;
        y_fp_d   = y_fp_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        vxi_d    = vxi_q;
        vyi_d    = vyi_q;
        x_pos_d  = x_pos_q;
        y_pos_d  = y_pos_q;
        active_d = active_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctl.throw) begin
                    vxi_d   = ctl.vx_init;
                    vyi_d   = ctl.vy_init;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ctl.frame_tick) begin
                    x_fp_d   = 18'(START_X * 16);
                    y_fp_d   = 18'(START_Y * 16);
                    vx_d     = {4'd0, vxi_q};
                    vy_d     = {4'd0, vyi_q};
                    x_pos_d  = 12'(START_X);
                    y_pos_d  = 12'(START_Y);
                    active_d = 1'b1;
                    state_d  = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (ctl.frame_tick) begin
                    x_fp_d  = w_x_new;
                    y_fp_d  = w_ground ? 18'sd0 : w_y_new;
                    vx_d    = w_vx_sat;
                    vy_d    = w_vy_sat;
                    x_pos_d = w_x_clamp;
                    y_pos_d = w_y_clamp;
                    if (w_hit) begin
                        hit_d   = 1'b1;
                        state_d = S_LANDED;
                    end else if (w_ground || w_edge) begin
                        miss_d  = 1'b1;
                        state_d = S_LANDED;
                    end
                end
            end
            S_LANDED: begin
                if (ctl.frame_tick) begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_fp_q   <= 18'(START_X * 16);
            y_fp_q   <= 18'(START_Y * 16);
            vx_q     <= 12'sd0;
            vy_q     <= 12'sd0;
            vxi_q    <= 8'd0;
            vyi_q    <= 8'd0;
            x_pos_q  <= 12'(START_X);
            y_pos_q  <= 12'(START_Y);
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_fp_q   <= x_fp_d;
            y_fp_q   <= y_fp_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            vxi_q    <= vxi_d;
            vyi_q    <= vyi_d;
            x_pos_q  <= x_pos_d;
            y_pos_q  <= y_pos_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign ctl.active = active_q;
    assign ctl.x_pos  = x_pos_q;
    assign ctl.y_pos  = y_pos_q;
    assign ctl.busy   = (state_q != S_IDLE);
    assign ctl.hit    = hit_q;
    assign ctl.miss   = miss_q;
endmodule
`default_nettype wire
